// File: rtl/bcd_seg_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_seg_scan                                                    |
// | Brief    : Double-buffered, blank-slotted 7-seg scanner for packed BCD.    |
// |            Optional macro BCD_SEG_LZB_EN enables leading-zero blanking.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bcd_seg_scan #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0]    C_SEG_BLANK = 7'h7F;
  localparam logic [PW-1:0] C_PCNT_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] C_IDX_LAST  = IW'(DIGITS - 1);

  logic [PW-1:0]         r_pcnt;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_pend;
  logic                  r_pend_v;
  logic [4*DIGITS-1:0]   r_disp;

  logic                  w_pwrap;
  logic                  w_boundary;
  logic [3:0]            w_digit [DIGITS];
  logic [3:0]            w_cur;
  logic [6:0]            w_seg_next;
  logic [DIGITS-1:0]     w_an_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  assign w_pwrap    = (r_pcnt == C_PCNT_LAST);
  assign w_boundary = w_pwrap && (r_idx == C_IDX_LAST);

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      assign w_digit[i] = r_disp[4*i +: 4];
    end
  endgenerate

  assign w_cur = w_digit[r_idx];

`ifdef BCD_SEG_LZB_EN
  // w_blank[k]: digit k and every digit above it are zero; digit 0 is never blanked.
  logic [DIGITS-1:0] w_blank;
  assign w_blank[0] = 1'b0;
  generate
    for (genvar i = 1; i < DIGITS; i++) begin : g_lzb
      if (i == DIGITS - 1) begin : g_top
        assign w_blank[i] = (w_digit[i] == 4'd0);
      end else begin : g_mid
        assign w_blank[i] = (w_digit[i] == 4'd0) && w_blank[i+1];
      end
    end
  endgenerate
`endif

  // Slot pcnt==0 is a dark gap between digits to suppress ghosting.
  always_comb begin
    w_seg_next = C_SEG_BLANK;
    w_an_next  = '1;
    if (r_pcnt != '0) begin
      w_an_next  = ~(DIGITS'(1) << r_idx);
      w_seg_next = seg_decode(w_cur);
`ifdef BCD_SEG_LZB_EN
      if (w_blank[r_idx]) begin
        w_seg_next = C_SEG_BLANK;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt     <= '0;
      r_idx      <= '0;
      r_pend     <= '0;
      r_pend_v   <= 1'b0;
      r_disp     <= '0;
      seg_n      <= C_SEG_BLANK;
      an_n       <= '1;
      frame_tick <= 1'b0;
    end else begin
      r_pcnt <= w_pwrap ? '0 : r_pcnt + 1'b1;
      if (w_pwrap) begin
        r_idx <= (r_idx == C_IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      // A load on the boundary bypasses the pending buffer and drops any older value.
      if (w_boundary) begin
        r_pend_v <= 1'b0;
        if (load) begin
          r_disp <= bcd_in;
        end else if (r_pend_v) begin
          r_disp <= r_pend;
        end
      end else if (load) begin
        r_pend   <= bcd_in;
        r_pend_v <= 1'b1;
      end
      seg_n      <= w_seg_next;
      an_n       <= w_an_next;
      frame_tick <= w_boundary;
    end
  end

endmodule
`default_nettype wire
